// File: rtl/cache_arbiter_pkg.sv
// Shared types and helpers for the I/D cache miss-path arbiter.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  // Line-aligned address: the byte offset within a 32-byte line is dropped.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: decides who owns the memory port and tracks the last grant.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | port free; a pending request is granted here
// SERVE_I | I-cache line transfer in flight
// SERVE_D | D-cache line transfer in flight
// RELEASE | one-cycle gap so the served requester can drop
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_i,
  input  logic       i_req_d,
  input  logic       i_pmem_resp,
  output arb_state_t o_state,
  output logic       o_grant,
  output arb_grant_t o_grant_sel
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  arb_grant_t r_last_grant;
  logic       w_grant;
  arb_grant_t w_grant_sel;

  // State register and round-robin memory of the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last_grant <= w_grant_sel;
      end
    end
  end

  // Next-state and grant decision; a tie goes to whoever was not served last.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_sel  = GRANT_I;
    case (r_state)
      IDLE: begin
        if (i_req_i && i_req_d) begin
          w_grant = 1'b1;
          if (r_last_grant == GRANT_I) begin
            w_grant_sel = GRANT_D;
          end else begin
            w_grant_sel = GRANT_I;
          end
        end else if (i_req_i) begin
          w_grant     = 1'b1;
          w_grant_sel = GRANT_I;
        end else if (i_req_d) begin
          w_grant     = 1'b1;
          w_grant_sel = GRANT_D;
        end
        if (w_grant) begin
          if (w_grant_sel == GRANT_D) begin
            w_state_next = SERVE_D;
          end else begin
            w_state_next = SERVE_I;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (i_pmem_resp) begin
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_state     = r_state;
  assign o_grant     = w_grant;
  assign o_grant_sel = w_grant_sel;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths.
// One line transfer at a time; command, address and data are frozen at grant.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [31:0]       icache_addr,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [31:0]       dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  contention_cnt
);

  arb_state_t        w_state;
  logic              w_grant;
  arb_grant_t        w_grant_sel;
  logic              w_req_d;
  logic              w_serving;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [31:0]       r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;
  logic [CNT_W-1:0]  r_contention_cnt;

  assign w_req_d   = dcache_read | dcache_write;
  assign w_serving = (w_state == SERVE_I) || (w_state == SERVE_D);

  cache_arbiter_control u_control (
    .clk         (clk),
    .rst         (rst),
    .i_req_i     (icache_read),
    .i_req_d     (w_req_d),
    .i_pmem_resp (pmem_resp),
    .o_state     (w_state),
    .o_grant     (w_grant),
    .o_grant_sel (w_grant_sel)
  );

  // Capture the granted command; drop the op strobe once memory responds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else if (w_grant) begin
      if (w_grant_sel == GRANT_D) begin
        r_pmem_address <= line_addr(dcache_addr);
        // Read and write both asserted: the writeback goes first.
        r_pmem_write   <= dcache_write;
        r_pmem_read    <= ~dcache_write;
        if (dcache_write) begin
          r_pmem_wdata <= dcache_wdata;
        end
      end else begin
        r_pmem_address <= line_addr(icache_addr);
        r_pmem_read    <= 1'b1;
        r_pmem_write   <= 1'b0;
      end
    end else if (pmem_resp && w_serving) begin
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end
  end

  // Count cycles the I side is stalled behind a D transfer; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_contention_cnt <= '0;
    end else if ((w_state == SERVE_D) && icache_read && (r_contention_cnt != '1)) begin
      r_contention_cnt <= r_contention_cnt + CNT_W'(1);
    end
  end

  assign icache_resp    = pmem_resp && (w_state == SERVE_I);
  assign dcache_resp    = pmem_resp && (w_state == SERVE_D);
  assign icache_rdata   = pmem_rdata;
  assign dcache_rdata   = pmem_rdata;
  assign pmem_read      = r_pmem_read;
  assign pmem_write     = r_pmem_write;
  assign pmem_address   = r_pmem_address;
  assign pmem_wdata     = r_pmem_wdata;
  assign contention_cnt = r_contention_cnt;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level port-ownership model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_read;
  logic [31:0]   icache_addr;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read;
  logic          dcache_write;
  logic [31:0]   dcache_addr;
  logic [LW-1:0] dcache_wdata;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [CW-1:0] contention_cnt;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_addr    (icache_addr),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_addr    (dcache_addr),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .contention_cnt (contention_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D), idle gap after a
  // response, who was served last, and the command memory should be seeing.
  int            m_owner = 0;
  int            m_gap   = 0;
  int            m_last  = 1;
  int            m_lat   = 0;
  logic          m_rd    = 1'b0;
  logic          m_wr    = 1'b0;
  logic [31:0]   m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;
  int            m_cnt   = 0;
  bit            i_done  = 0;
  bit            d_done  = 0;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_update();
    int pick;
    if (rst) begin
      m_owner = 0; m_gap = 0; m_last = 1; m_rd = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_cnt = 0;
      return;
    end
    if (m_owner == 2 && icache_read && m_cnt < (1 << CW) - 1) m_cnt++;
    if (m_owner != 0) begin
      if (pmem_resp) begin
        if (m_owner == 1) i_done = 1; else d_done = 1;
        m_owner = 0; m_gap = 1; m_rd = 0; m_wr = 0;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      pick = 0;
      if (icache_read && (dcache_read || dcache_write)) pick = (m_last == 1) ? 2 : 1;
      else if (icache_read) pick = 1;
      else if (dcache_read || dcache_write) pick = 2;
      if (pick == 1) begin
        m_addr = {icache_addr[31:5], 5'b0};
        m_rd = 1; m_wr = 0;
      end else if (pick == 2) begin
        m_addr = {dcache_addr[31:5], 5'b0};
        if (dcache_write) begin
          m_wr = 1; m_rd = 0; m_wdata = dcache_wdata;
        end else begin
          m_rd = 1; m_wr = 0;
        end
      end
      if (pick != 0) begin
        m_owner = pick; m_last = pick; m_lat = $urandom_range(0, 4);
      end
    end
  endtask

  task automatic check_outputs();
    check_val("pmem_read", LW'(pmem_read), LW'(m_rd));
    check_val("pmem_write", LW'(pmem_write), LW'(m_wr));
    check_val("pmem_address", LW'(pmem_address), LW'(m_addr));
    check_val("pmem_wdata", pmem_wdata, m_wdata);
    check_val("icache_resp", LW'(icache_resp), LW'(pmem_resp && m_owner == 1));
    check_val("dcache_resp", LW'(dcache_resp), LW'(pmem_resp && m_owner == 2));
    if (pmem_resp && m_owner == 1) check_val("icache_rdata", icache_rdata, pmem_rdata);
    if (pmem_resp && m_owner == 2) check_val("dcache_rdata", dcache_rdata, pmem_rdata);
    check_val("contention_cnt", LW'(contention_cnt), LW'(m_cnt));
  endtask

  // Inputs are set at the falling edge before calling this.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    icache_read = 0; icache_addr = '0; dcache_read = 0; dcache_write = 0;
    dcache_addr = '0; dcache_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic rand_drive();
    int k;
    icache_addr  = $urandom;
    dcache_addr  = $urandom;
    dcache_wdata = rand_line();
    pmem_rdata   = rand_line();
    rst          = ($urandom_range(0, 199) == 0);
    if (i_done) begin
      icache_read = 0; i_done = 0;
    end else if (!icache_read) begin
      icache_read = ($urandom_range(0, 2) == 0);
    end else if (m_owner != 1 && $urandom_range(0, 19) == 0) begin
      icache_read = 0;
    end
    if (d_done) begin
      dcache_read = 0; dcache_write = 0; d_done = 0;
    end else if (!(dcache_read || dcache_write)) begin
      k = $urandom_range(0, 5);
      dcache_read  = (k == 0 || k == 2);
      dcache_write = (k == 1 || k == 2);
    end else if (m_owner != 2 && $urandom_range(0, 19) == 0) begin
      dcache_read = 0; dcache_write = 0;
    end
    if (m_owner != 0) begin
      if (m_lat == 0) pmem_resp = 1;
      else begin pmem_resp = 0; m_lat--; end
    end else begin
      pmem_resp = ($urandom_range(0, 9) == 0);
    end
  endtask

  logic [LW-1:0] t_line;

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);
    tick();
    rst = 0;
    check_val("rst_read", LW'(pmem_read), '0);
    check_val("rst_addr", LW'(pmem_address), '0);
    check_val("rst_cnt", LW'(contention_cnt), '0);

    // Single I-cache read with unaligned address.
    icache_read = 1; icache_addr = 32'h0000_0064; tick();
    check_val("t2_read", LW'(pmem_read), LW'(1'b1));
    check_val("t2_addr", LW'(pmem_address), LW'(32'h0000_0060));
    icache_addr = $urandom;
    repeat (3) tick();
    pmem_resp = 1; t_line = rand_line(); pmem_rdata = t_line; #1;
    check_val("t2_iresp", LW'(icache_resp), LW'(1'b1));
    check_val("t2_dresp", LW'(dcache_resp), '0);
    check_val("t2_rdata", icache_rdata, t_line);
    tick();
    icache_read = 0; pmem_resp = 0;
    check_val("t2_release", LW'(pmem_read), '0);
    tick(); tick();

    // First tie after reset goes to D; I follows at t+k+3.
    do_reset();
    icache_read = 1; icache_addr = 32'h0000_5678;
    dcache_read = 1; dcache_addr = 32'h0000_1234; tick();
    check_val("t3_d_first", LW'(pmem_address), LW'(32'h0000_1220));
    repeat (3) tick();
    pmem_resp = 1; #1;
    check_val("t3_dresp", LW'(dcache_resp), LW'(1'b1));
    check_val("t3_iresp", LW'(icache_resp), '0);
    tick();
    dcache_read = 0; pmem_resp = 0;
    check_val("t3_cnt", LW'(contention_cnt), LW'(4));
    tick();
    check_val("t3_idle_gap", LW'(pmem_read), '0);
    tick();
    check_val("t3_i_read", LW'(pmem_read), LW'(1'b1));
    check_val("t3_i_addr", LW'(pmem_address), LW'(32'h0000_5660));
    pmem_resp = 1; tick();
    icache_read = 0; pmem_resp = 0; tick(); tick();

    // After a D round a tie goes to I, then back to D.
    dcache_read = 1; dcache_addr = 32'h0000_0200; tick();
    pmem_resp = 1; tick();
    dcache_read = 0; pmem_resp = 0; tick(); tick();
    icache_read = 1; icache_addr = 32'h0000_0300;
    dcache_read = 1; dcache_addr = 32'h0000_0400; tick();
    check_val("t4_i_wins", LW'(pmem_address), LW'(32'h0000_0300));
    pmem_resp = 1; tick();
    icache_read = 0; dcache_read = 0; pmem_resp = 0; tick(); tick();
    icache_read = 1; dcache_read = 1; tick();
    check_val("t4_alt_d", LW'(pmem_address), LW'(32'h0000_0400));
    pmem_resp = 1; tick();
    icache_read = 0; dcache_read = 0; pmem_resp = 0; tick(); tick();

    // Read+write together: write wins and its data is frozen.
    dcache_read = 1; dcache_write = 1; dcache_addr = 32'h0000_0040;
    dcache_wdata = {32{8'hA5}}; tick();
    check_val("t5_write", LW'(pmem_write), LW'(1'b1));
    check_val("t5_read", LW'(pmem_read), '0);
    for (int i = 0; i < 3; i++) begin
      dcache_wdata = rand_line(); tick();
      check_val("t5_hold", pmem_wdata, {32{8'hA5}});
    end
    pmem_resp = 1; tick();
    dcache_read = 0; dcache_write = 0; pmem_resp = 0; tick(); tick();

    // Spurious response in IDLE, then reset in the middle of an I transfer.
    pmem_resp = 1; #1;
    check_val("t6_no_iresp", LW'(icache_resp), '0);
    check_val("t6_no_dresp", LW'(dcache_resp), '0);
    tick();
    pmem_resp = 0; icache_read = 1; icache_addr = 32'h0000_0800; tick();
    check_val("t6_grant", LW'(pmem_read), LW'(1'b1));
    tick();
    rst = 1; tick();
    rst = 0;
    check_val("t7_rst_read", LW'(pmem_read), '0);
    icache_read = 0; pmem_resp = 1; #1;
    check_val("t7_no_resp", LW'(icache_resp), '0);
    tick();
    pmem_resp = 0; tick();

    // Counter saturation with the 4-bit build.
    do_reset();
    icache_read = 1; dcache_read = 1; tick();
    repeat (20) tick();
    check_val("t8_sat", LW'(contention_cnt), LW'(15));
    pmem_resp = 1; tick();
    dcache_read = 0; pmem_resp = 0; tick(); tick();
    pmem_resp = 1; tick();
    icache_read = 0; pmem_resp = 0; tick(); tick();
    check_val("t8_no_wrap", LW'(contention_cnt), LW'(15));

    // Randomized traffic.
    clear_inputs(); do_reset();
    i_done = 0; d_done = 0;
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      tick();
    end
    clear_inputs(); rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares a single physical-memory port between the I-cache miss path, which feeds the IF stage's imem interface, and the D-cache miss path, which feeds the MEM stage's dmem interface.
- One line transfer (256 bits) is in flight at a time.
- Requests are granted round-robin when both paths are pending.
- Address and write data are latched at grant.
- The response is routed back only to the granted requester.
- A saturating contention counter feeds the performance-counter block.

## Interface
Parameters:
- LINE_W, 256, cache line width in bits
- CNT_W, 32, contention counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- icache_read  in  1  I-cache line read request; held until icache_resp
- icache_addr  in  32  line address (bits [4:0] ignored, forced to 0 downstream)
- icache_rdata  out  LINE_W  line data; valid only when icache_resp=1
- icache_resp  out  1  one-cycle completion pulse
- dcache_read  in  1  D-cache line read request; held until dcache_resp
- dcache_write  in  1  D-cache line writeback request; held until dcache_resp
- dcache_addr  in  32  line address
- dcache_wdata  in  LINE_W  writeback data
- dcache_rdata  out  LINE_W  line data; valid only when dcache_resp=1
- dcache_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  downstream read
- pmem_write  out  1  downstream write
- pmem_address  out  32  latched address, [4:0]=0
- pmem_wdata  out  LINE_W  latched write data
- pmem_rdata  in  LINE_W  downstream read data
- pmem_resp  in  1  downstream completion pulse
- contention_cnt  out  CNT_W  cycles an icache request waited while a D transfer was active

## Operation
- States:
  - IDLE: no transfer; pmem_read and pmem_write are 0.
  - SERVE_I: I-cache transfer on the port.
  - SERVE_D: D-cache transfer on the port.
  - RELEASE: one-cycle gap after a response.
- Transitions:
  - IDLE → SERVE_I if only icache_read is pending.
  - IDLE → SERVE_D if only a D request (read or write) is pending.
  - IDLE, both pending: grant the requester not served last. The last_grant flag resets to I, so the first tie goes to D.
  - SERVE_x → RELEASE on pmem_resp.
  - RELEASE → IDLE unconditionally. This gives the requester one cycle to drop its request, so a stale request is never re-granted.
- Grant actions:
  - Latch pmem_address = {addr[31:5], 5'b0}.
  - For a D write, also latch pmem_wdata.
  - Latch the operation: pmem_write=1 if dcache_write, else pmem_read=1.
  - If dcache_read and dcache_write are both high, the write wins.
  - Update last_grant.
- pmem_read, pmem_write, pmem_address and pmem_wdata are registered. They stay stable for the whole SERVE state, regardless of requester inputs.
- Responses:
  - icache_resp = pmem_resp && state==SERVE_I.
  - dcache_resp = pmem_resp && state==SERVE_D.
  - Both are combinational.
  - rdata outputs pass pmem_rdata straight through; they are don't-care when resp=0.
- contention_cnt increments each cycle that state==SERVE_D && icache_read. It saturates at all-ones and never wraps.
- Reset values: state=IDLE; last_grant=I; pmem_read=0; pmem_write=0; pmem_address=0; pmem_wdata=0; contention_cnt=0. Both resp outputs are 0 because state is IDLE.

## Timing
- Request seen in IDLE at cycle t → pmem_read or pmem_write high from t+1.
- pmem_resp at cycle t+k → requester resp in the same cycle t+k; pmem_read/pmem_write low at t+k+1 (RELEASE); IDLE at t+k+2.
- Minimum per-transfer occupancy: 3 cycles plus downstream latency.
- Back-to-back requests from the other requester are granted in the IDLE cycle, so their pmem op starts at t+k+3.
- pmem_resp outside SERVE_x is ignored. No resp is generated and no state changes.
- Reset asserted mid-transfer: next cycle is IDLE with pmem ops deasserted. The in-flight transfer is abandoned and no resp is issued.
- A request dropped before grant is never granted. A request dropped while being served is illegal; the transfer still completes.

## Structure
- Shared package rv32i_types gains arb_state_t (IDLE, SERVE_I, SERVE_D, RELEASE) and arb_grant_t (GRANT_I, GRANT_D).
- One sub-module is natural: arbiter_control (next-state and grant logic, last_grant flag).
- The top level holds the latched address/data registers, the response routing and the saturating counter, using the existing register module for the latches.

## Test plan
- Reset, then icache_read with icache_addr=0x0000_0064 → pmem_read=1 at t+1 with pmem_address=0x0000_0060; pmem_resp after 4 cycles → icache_resp=1 for one cycle, icache_rdata=pmem_rdata, dcache_resp=0.
- Tie after reset: icache_read and dcache_read asserted in the same cycle → D served first; after its RELEASE, I granted and pmem_read rises at t+k+3; contention_cnt equals the number of SERVE_D cycles.
- Second tie after a D-first round → I granted (round-robin alternation).
- dcache_read and dcache_write both high, wdata=0xA5…A5 → pmem_write=1, pmem_read=0, pmem_wdata=0xA5…A5 held stable while dcache_wdata changes.
- Spurious pmem_resp in IDLE → no resp output, state unchanged; rst during SERVE_I → IDLE and pmem_read=0 the next cycle, no icache_resp.
- Force contention_cnt near all-ones (CNT_W=4 build) → saturates at 15, no wrap.
